fetch_unit: RTL and testbench

Instruction-fetch stage of the pipeline: owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register. It sits directly upstream of the branch-resolution logic and consumes that logic's redirect outputs (`PcSel`, `BrPC`, `Halt`). On a redirect it squashes the wrong-path fetch. It also freezes the front end permanently once a halt is resolved.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/pc_register.sv | 39 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types and constants shared by the fetch and decode stages.
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t : front-end state, RUN or HALTED
//   if_id_t       : IF/ID pipeline register contents {pc, instr, valid}
//   if_id_bubble(): IF/ID value that carries no instruction
package pipeline_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

   // pc is full width so the ID stage can reuse the struct regardless of PC_W.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_t;

   function automatic if_id_t if_id_bubble();
      if_id_t b;
      b.pc    = '0;
      b.instr = NOP_INSTR;
      b.valid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/pc_register.sv
// pc_register: program-counter flop and next-PC mux.
//   clk, reset  : clock and synchronous active-high reset (PC <= RESET_PC)
//   load_en     : update the PC this edge; otherwise it holds
//   sel_target  : 1 = load the word-aligned redirect target, 0 = PC + 4
//   target_word : redirect target with the byte-offset bits already removed
//   pc          : current PC
module pc_register #(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_en,
   input  logic            sel_target,
   input  logic [PC_W-3:0] target_word,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pc_q;

   always_comb begin
      // NOTE: default assignment first, so every path drives pc_d and no latch is inferred.
      pc_d = pc_q;
      if (load_en) begin
         // PC + 4 wraps naturally at PC_W bits.
         pc_d = sel_target ? {target_word, 2'b00} : pc_q + PC_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks so all flops sample together.
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, loads IF/ID, squashes the
// wrong-path fetch on a redirect and freezes the front end once a halt resolves.
//   clk, reset   : clock and synchronous active-high reset
//   Stall        : hazard hold of PC and IF/ID
//   PcSel, BrPC  : redirect request and target byte address
//   Halt         : redirecting instruction is a halt (qualified by PcSel)
//   Instr_in     : combinational instruction-memory data at Pc_out
//   Pc_out       : current PC / instruction-memory address
//   IfId_*       : IF/ID register contents
//   Flush        : combinational copy of PcSel for the ID/EX squash
//   Halted       : front end frozen until reset
//   MisalignErr  : sticky, a redirect target had nonzero low bits
//   FetchCount   : valid instructions loaded into IF/ID (wraps)
module fetch_unit
   import pipeline_pkg::*;
#(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Stall,
   input  logic            PcSel,
   input  logic [31:0]     BrPC,
   input  logic            Halt,
   input  logic [31:0]     Instr_in,
   output logic [PC_W-1:0] Pc_out,
   output logic [PC_W-1:0] IfId_PC,
   output logic [31:0]     IfId_Instr,
   output logic            IfId_Valid,
   output logic            Flush,
   output logic            Halted,
   output logic            MisalignErr,
   output logic [31:0]     FetchCount
);

   fetch_state_t state_d, state_q;
   if_id_t       if_id_d, if_id_q;
   logic [31:0]  fetch_count_d, fetch_count_q;
   logic         misalign_d, misalign_q;

   logic         redirect;
   logic         advance;

   // Redirect outranks Stall because the redirecting instruction is older;
   // in HALTED every request is ignored.
   assign redirect = (state_q == RUN) && PcSel;
   assign advance  = (state_q == RUN) && !PcSel && !Stall;

   pc_register #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk         (clk),
      .reset       (reset),
      .load_en     (redirect || advance),
      .sel_target  (redirect),
      .target_word (BrPC[PC_W-1:2]),
      .pc          (Pc_out)
   );

   always_comb begin
      state_d       = state_q;
      if_id_d       = if_id_q;
      fetch_count_d = fetch_count_q;
      misalign_d    = misalign_q;
      if (redirect) begin
         if_id_d    = if_id_bubble();
         misalign_d = misalign_q || (BrPC[1:0] != 2'b00);
         if (Halt) state_d = HALTED;
      end else if (advance) begin
         if_id_d.pc    = 32'(Pc_out);
         if_id_d.instr = Instr_in;
         if_id_d.valid = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= RUN;
         if_id_q       <= if_id_bubble();
         fetch_count_q <= '0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         if_id_q       <= if_id_d;
         fetch_count_q <= fetch_count_d;
         misalign_q    <= misalign_d;
      end
   end

   assign IfId_PC     = if_id_q.pc[PC_W-1:0];
   assign IfId_Instr  = if_id_q.instr;
   assign IfId_Valid  = if_id_q.valid;
   assign Flush       = PcSel;
   assign Halted      = (state_q == HALTED);
   assign MisalignErr = misalign_q;
   assign FetchCount  = fetch_count_q;

   // Address bits above the PC width are dropped by design.
   logic unused_hi_bits;
   assign unused_hi_bits = ^{BrPC[31:PC_W], if_id_q.pc[31:PC_W]};

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. The driver applies one
// input vector per cycle, advances a behavioural model of the fetch stage and
// queues the expected post-edge outputs; a monitor pops and compares them
// after every rising edge.
module tb_fetch_unit;
   import pipeline_pkg::*;

   localparam int          PC_W   = 9;
   localparam int unsigned PC_MOD = 1 << PC_W;

   logic            clk;
   logic            reset;
   logic            Stall;
   logic            PcSel;
   logic [31:0]     BrPC;
   logic            Halt;
   logic [31:0]     Instr_in;
   logic [PC_W-1:0] Pc_out;
   logic [PC_W-1:0] IfId_PC;
   logic [31:0]     IfId_Instr;
   logic            IfId_Valid;
   logic            Flush;
   logic            Halted;
   logic            MisalignErr;
   logic [31:0]     FetchCount;

   fetch_unit #(
      .PC_W     (PC_W),
      .RESET_PC (9'd0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Stall       (Stall),
      .PcSel       (PcSel),
      .BrPC        (BrPC),
      .Halt        (Halt),
      .Instr_in    (Instr_in),
      .Pc_out      (Pc_out),
      .IfId_PC     (IfId_PC),
      .IfId_Instr  (IfId_Instr),
      .IfId_Valid  (IfId_Valid),
      .Flush       (Flush),
      .Halted      (Halted),
      .MisalignErr (MisalignErr),
      .FetchCount  (FetchCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: one word per 4-byte slot of the PC space.
   logic [31:0] mem [0:PC_MOD/4-1];
   assign Instr_in = mem[Pc_out[PC_W-1:2]];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] if_pc;
      logic [31:0] if_instr;
      logic        if_valid;
      logic [31:0] cnt;
      logic        halted;
      logic        mis;
   } exp_t;

   exp_t exp_q [$];

   // Reference model state, kept as plain byte addresses and counters.
   int unsigned m_pc;
   int unsigned m_if_pc;
   logic [31:0] m_if_instr;
   bit          m_if_valid;
   logic [31:0] m_cnt;
   bit          m_halted;
   bit          m_mis;

   task automatic model_step(input bit rst, input bit stl, input bit sel,
                             input logic [31:0] br, input bit hlt);
      if (rst) begin
         m_pc = 0; m_if_pc = 0; m_if_instr = 32'h13; m_if_valid = 0;
         m_cnt = 0; m_halted = 0; m_mis = 0;
      end else if (!m_halted) begin
         if (sel) begin
            m_pc       = (br % PC_MOD) & ~32'd3;
            m_if_pc    = 0;
            m_if_instr = 32'h13;
            m_if_valid = 0;
            if (br % 4 != 0) m_mis = 1;
            if (hlt) m_halted = 1;
         end else if (!stl) begin
            m_if_pc    = m_pc;
            m_if_instr = mem[m_pc / 4];
            m_if_valid = 1;
            m_pc       = (m_pc + 4) % PC_MOD;
            m_cnt      = m_cnt + 1;
         end
      end
   endtask

   // One clock: drive at the falling edge, queue the expectation, return just
   // after the rising edge so directed checks can look at the new state.
   task automatic cycle(input bit rst, input bit stl, input bit sel,
                        input logic [31:0] br, input bit hlt);
      exp_t e;
      @(negedge clk);
      reset = rst; Stall = stl; PcSel = sel; BrPC = br; Halt = hlt;
      #1;
      check("flush", 32'(Flush), 32'(sel));
      model_step(rst, stl, sel, br, hlt);
      e.pc       = m_pc;
      e.if_pc    = m_if_pc;
      e.if_instr = m_if_instr;
      e.if_valid = m_if_valid;
      e.cnt      = m_cnt;
      e.halted   = m_halted;
      e.mis      = m_mis;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 0);
   endtask

   // Monitor: every rising edge the DUT presents a new registered state.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("pc_out",     32'(Pc_out),      e.pc);
         check("ifid_pc",    32'(IfId_PC),     e.if_pc);
         check("ifid_instr", IfId_Instr,       e.if_instr);
         check("ifid_valid", 32'(IfId_Valid),  32'(e.if_valid));
         check("fetch_cnt",  FetchCount,       e.cnt);
         check("halted",     32'(Halted),      32'(e.halted));
         check("misalign",   32'(MisalignErr), 32'(e.mis));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; Stall = 1'b0; PcSel = 1'b0; BrPC = '0; Halt = 1'b0;
      for (int i = 0; i < PC_MOD / 4; i++) mem[i] = 32'hA0 + 32'(4 * i);

      // Reset for two cycles; Flush must track PcSel even under reset.
      cycle(1, 0, 0, 32'h0, 0);
      cycle(1, 1, 1, 32'h44, 1);
      check("rst_pc", 32'(Pc_out), 32'h0);

      // Run: third fetch is {8, 0xA8, 1}.
      adv(3);
      check("run_ifid_pc",    32'(IfId_PC), 32'h8);
      check("run_ifid_instr", IfId_Instr,   32'hA8);
      check("run_cnt",        FetchCount,   32'd3);

      // Stall three cycles at 0x10.
      adv(1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 32'h0, 0);
      check("stall_pc",  32'(Pc_out), 32'h10);
      check("stall_cnt", FetchCount,  32'd4);
      adv(1);
      check("resume_pc", 32'(Pc_out), 32'h14);

      // Redirect under stall at 0x20.
      adv(3);
      cycle(0, 1, 1, 32'h40, 0);
      check("redir_pc",    32'(Pc_out), 32'h40);
      check("redir_nop",   IfId_Instr,  NOP_INSTR);
      adv(1);
      check("redir_fetch", IfId_Instr,  32'hE0);

      // Halt, then ignored redirects, then reset.
      cycle(0, 0, 1, 32'h18, 1);
      check("halt_pc", 32'(Pc_out), 32'h18);
      cycle(0, 1, 1, 32'h80, 0);
      cycle(0, 0, 1, 32'h80, 1);
      check("halt_hold_pc", 32'(Pc_out), 32'h18);
      check("halt_flag",    32'(Halted), 32'h1);
      cycle(1, 0, 0, 32'h0, 0);
      check("halt_rst_pc",  32'(Pc_out), 32'h0);
      check("halt_rst_flg", 32'(Halted), 32'h0);
      adv(2);

      // Wrap-around and misaligned redirect with dropped upper bits.
      cycle(0, 0, 1, 32'h1FC, 0);
      adv(1);
      check("wrap_pc", 32'(Pc_out), 32'h0);
      cycle(0, 0, 1, 32'h0001_0046, 0);
      check("mis_pc", 32'(Pc_out), 32'h44);
      adv(3);
      check("mis_sticky", 32'(MisalignErr), 32'h1);
      cycle(1, 0, 0, 32'h0, 0);
      adv(1);

      // Randomized traffic over random memory contents.
      for (int i = 0; i < PC_MOD / 4; i++) mem[i] = $urandom;
      for (int i = 0; i < 3000; i++) begin
         bit rst, stl, sel, hlt;
         rst = ($urandom_range(99) < 3);
         stl = ($urandom_range(99) < 25);
         sel = ($urandom_range(99) < 12);
         hlt = ($urandom_range(99) < 15);
         cycle(rst, stl, sel, $urandom, hlt);
      end

      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
